// File: rtl/freq_div_pkg.sv
// Shared types and default sizing for the calibrated frequency divider.
// The divider measures one high phase of infreq and then emits f_in / 2^n.
package freq_div_pkg;

  localparam int DEF_CNT_W = 8;
  localparam int DEF_N_W   = 3;
  localparam int DEF_HP_W  = DEF_CNT_W + 7;

  // Largest measurable high width; reaching it raises the ovf flag.
  localparam logic [DEF_CNT_W-1:0] K_MAX = {DEF_CNT_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARMED     = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    LOAD      = 3'd4,
    RUN       = 3'd5
  } state_e;

endpackage

// File: rtl/edge_sync.sv
// Brings the asynchronous infreq into the clk domain.
// Also provides single-cycle rise/fall strobes of the synchronised level.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // NOTE: non-blocking assignments so every flop samples its pre-edge input;
  // blocking here would collapse the chain into a single flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign s_o    = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/freq_divider.sv
// Calibrated divider: measures the high width k of infreq in clk cycles,
// then toggles outfreq every (k << n) cycles until the next adjust.
module freq_divider
  import freq_div_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int N_W   = DEF_N_W,
  parameter int HP_W  = DEF_HP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             infreq,
  input  logic             adjust,
  input  logic [N_W-1:0]   n,
  output logic             outfreq,
  output logic             valid,
  output logic [CNT_W-1:0] k,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic s, rise, fall;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  k_q, k_d;
  logic              ovf_q, ovf_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic [HP_W-1:0]   dcnt_q, dcnt_d;
  logic              outfreq_q, outfreq_d;
  logic              valid_q, valid_d;
  logic [HP_W-1:0]   hp_load;

  edge_sync u_edge_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (infreq),
    .s_o    (s),
    .rise_o (rise),
    .fall_o (fall)
  );

  // HP_W is wide enough for k shifted by the largest n, so nothing is lost.
  assign hp_load = HP_W'(k_q) << n;

  // NOTE: every variable gets its hold value first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    ovf_d     = ovf_q;
    hp_d      = hp_q;
    dcnt_d    = dcnt_q;
    outfreq_d = outfreq_q;
    valid_d   = valid_q;

    if (adjust) begin
      // Calibration request wins over any edge or toggle and drops the output.
      state_d   = ARMED;
      valid_d   = 1'b0;
      outfreq_d = 1'b0;
      ovf_d     = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        ARMED: state_d = WAIT_RISE;
        WAIT_RISE: begin
          if (rise) begin
            cnt_d   = CNT_W'(1);
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          if (fall) begin
            k_d     = cnt_q;
            state_d = LOAD;
          end else if (s) begin
            if (cnt_q == CNT_MAX) ovf_d = 1'b1;
            else                  cnt_d = cnt_q + 1'b1;
          end
        end
        LOAD: begin
          hp_d      = hp_load;
          dcnt_d    = hp_load;
          outfreq_d = 1'b1;
          valid_d   = 1'b1;
          state_d   = RUN;
        end
        RUN: begin
          if (dcnt_q == HP_W'(1)) begin
            outfreq_d = ~outfreq_q;
            dcnt_d    = hp_q;
          end else begin
            dcnt_d = dcnt_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      k_q       <= '0;
      ovf_q     <= 1'b0;
      hp_q      <= '0;
      dcnt_q    <= '0;
      outfreq_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      ovf_q     <= ovf_d;
      hp_q      <= hp_d;
      dcnt_q    <= dcnt_d;
      outfreq_q <= outfreq_d;
      valid_q   <= valid_d;
    end
  end

  assign outfreq = outfreq_q;
  assign valid   = valid_q;
  assign k       = k_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_freq_divider.sv
// Scoreboard bench for freq_divider: stimulus queues the expected k/ovf/half-period,
// a monitor checks them at each valid rise and on every completed outfreq level.
module tb_freq_divider;
  import freq_div_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       infreq;
  logic       adjust;
  logic [2:0] n;
  logic       outfreq;
  logic       valid;
  logic [7:0] k;
  logic       ovf;

  freq_divider dut (
    .clk     (clk),
    .rst     (rst),
    .infreq  (infreq),
    .adjust  (adjust),
    .n       (n),
    .outfreq (outfreq),
    .valid   (valid),
    .k       (k),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int k;
    int ovf;
    int hp;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks    = 0;
  int   n_fail      = 0;
  int   pushes      = 0;
  int   pops        = 0;
  int   levels_seen = 0;

  int hi_len = 10;
  int lo_len = 10;
  bit gen_on = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int ek, input int eovf, input int ehp);
    exp_t e;
    e.k = ek; e.ovf = eovf; e.hp = ehp;
    exp_q.push_back(e);
    pushes++;
  endtask

  task automatic pulse_adjust(input int cycles);
    @(negedge clk);
    adjust = 1'b1;
    repeat (cycles) @(negedge clk);
    adjust = 1'b0;
  endtask

  // Wait until the most recently pushed item has shown nlev full levels.
  task automatic wait_levels(input string name, input int nlev, input int budget);
    int cyc = 0;
    while (!(pops == pushes && levels_seen >= nlev) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check(name, (pops == pushes && levels_seen >= nlev), 1);
  endtask

  // infreq pattern, aligned to negedges so the high width is exact in clk cycles.
  initial begin
    infreq = 1'b0;
    forever begin
      @(negedge clk);
      if (gen_on) begin
        infreq = 1'b1;
        repeat (hi_len) @(negedge clk);
        infreq = 1'b0;
        repeat (lo_len - 1) @(negedge clk);
      end
    end
  end

  // Monitor: pops on each valid rise, then times every completed outfreq level.
  initial begin
    bit         valid_prev = 1'b0;
    bit         out_prev   = 1'b0;
    logic [7:0] k_prev     = '0;
    bit         active     = 1'b0;
    int         run_len    = 0;
    exp_t       cur;
    cur.k = 0; cur.ovf = 0; cur.hp = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 1'b0; valid_prev = 1'b0; out_prev = 1'b0; k_prev = '0;
      end else begin
        if (valid && !valid_prev) begin
          if (exp_q.size() == 0) begin
            check("unexpected_valid", valid, 0);
          end else begin
            cur = exp_q.pop_front();
            pops++;
            levels_seen = 0;
            check("k_at_valid", k, cur.k);
            check("k_one_cycle_before_valid", k_prev, cur.k);
            check("ovf_at_valid", ovf, cur.ovf);
            check("first_level_high", outfreq, 1);
            active  = 1'b1;
            run_len = 1;
          end
        end else if (valid && active) begin
          if (outfreq != out_prev) begin
            check("half_period", run_len, cur.hp);
            levels_seen++;
            run_len = 1;
          end else begin
            run_len++;
          end
        end
        if (!valid) active = 1'b0;
        valid_prev = valid;
        out_prev   = outfreq;
        k_prev     = k;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    bit  activity;
    rst    = 1'b1;
    adjust = 1'b0;
    n      = 3'd0;
    #1;
    check("reset_outfreq", outfreq, 0);
    check("reset_valid", valid, 0);
    check("reset_k", k, 0);
    check("reset_ovf", ovf, 0);
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    gen_on = 1'b1;

    // Divide by 4: H=10, n=2 -> k=10, half-period 40.
    n = 3'd2;
    push_exp(10, 0, 40);
    pulse_adjust(3);
    wait_levels("t1_levels", 4, 400);

    // No division: n=0 -> half-period 10; outputs drop the cycle after adjust.
    n = 3'd0;
    push_exp(10, 0, 10);
    @(negedge clk);
    adjust = 1'b1;
    @(negedge clk);
    check("t2_valid_after_adjust", valid, 0);
    check("t2_outfreq_after_adjust", outfreq, 0);
    adjust = 1'b0;
    wait_levels("t2_levels", 4, 200);

    // Saturation: H=300 with CNT_W=8 -> k=255, ovf, n=1 -> half-period 510.
    hi_len = 300; lo_len = 300; n = 3'd1;
    repeat (25) @(negedge clk);
    push_exp(255, 1, 510);
    pulse_adjust(2);
    wait_levels("t3_levels", 2, 3000);

    // Re-adjust during RUN: H=6, n=3 -> k=6, half-period 48, ovf cleared.
    hi_len = 6; lo_len = 6; n = 3'd3;
    repeat (610) @(negedge clk);
    check("t4_in_run", valid, 1);
    push_exp(6, 0, 48);
    @(negedge clk);
    adjust = 1'b1;
    @(negedge clk);
    check("t4_valid_after_adjust", valid, 0);
    check("t4_outfreq_after_adjust", outfreq, 0);
    check("t4_ovf_after_adjust", ovf, 0);
    adjust = 1'b0;
    wait_levels("t4_levels", 4, 500);

    // n change in RUN: measured with n=2, switched to 5; half-period stays 40.
    hi_len = 10; lo_len = 10; n = 3'd2;
    repeat (20) @(negedge clk);
    push_exp(10, 0, 40);
    pulse_adjust(2);
    wait_levels("t6_first_level", 1, 300);
    n = 3'd5;
    wait_levels("t6_levels", 4, 300);

    // Reset mid-measure: outputs and state return to reset values at once.
    pulse_adjust(2);
    cyc = 0;
    while (dut.state_q != MEASURE && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("t5_reached_measure", int'(dut.state_q), int'(MEASURE));
    rst = 1'b1;
    #1;
    check("t5_state_idle", int'(dut.state_q), int'(IDLE));
    check("t5_outfreq", outfreq, 0);
    check("t5_valid", valid, 0);
    check("t5_k", k, 0);
    check("t5_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    activity = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (valid || outfreq || dut.state_q != IDLE) activity = 1'b1;
    end
    check("t5_no_activity_without_adjust", activity, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/freq_divider.md
Name: freq_divider

Overview:
- Calibrated frequency divider: the counterpart to the team's frequency multiplier.
- Measures the high-phase width of a slow `infreq` in reference-clock cycles, then synthesises `outfreq` whose half-period is that width times 2^n, so that f_out = f_in / 2^n for a 50% duty input.
- Uses the same adjust/valid calibration handshake as the multiplier and sits beside it in the clock-generation datapath.

Parameters:
- CNT_W, 8: width of the measurement counter and of `k`.
- N_W, 3: width of the `n` divide exponent; maximum shift is 2^N_W-1.
- HP_W, CNT_W+7: width of the scaled half-period register; must be at least CNT_W + 2^N_W - 1.

Ports:
- clk      input   1       reference clock.
- rst      input   1       reset, asynchronous, active-high.
- infreq   input   1       sampled input frequency; asynchronous to clk.
- adjust   input   1       calibration request, level; high (re)arms measurement.
- n        input   N_W     divide exponent; output half-period = k << n.
- outfreq  output  1       divided output frequency.
- valid    output  1       high while outfreq is being generated from a completed measurement.
- k        output  CNT_W   measured high width of infreq, in clk cycles.
- ovf      output  1       sticky flag; measurement saturated at 2^CNT_W-1.

Behaviour:
- Reset (async, rst high): state=IDLE; outfreq=0, valid=0, k=0, ovf=0; synchroniser flops, counters and half-period register cleared.
- Input conditioning: infreq passes through a 2-flop synchroniser (2 clk latency) to give s. A prev register of s produces:
  - rise = s & ~prev
  - fall = ~s & prev
- IDLE: outputs held at 0. adjust=1 -> ARMED.
- ARMED: valid=0, outfreq=0, ovf cleared. Stay while adjust=1; adjust=0 -> WAIT_RISE.
- WAIT_RISE: on rise -> MEASURE, with cnt loaded to 1 in that cycle.
- MEASURE: each cycle with s=1, cnt <= cnt+1.
  - Saturation: at cnt = 2^CNT_W-1, cnt holds and ovf<=1.
  - On fall: k <= cnt, then -> LOAD.
  - Result: a high phase of exactly H clk cycles yields k=H.
- LOAD (1 cycle):
  - hp <= zero-extend(k) << n, computed in HP_W bits with no truncation.
  - dcnt <= that same value; outfreq <=1; valid <=1.
  - n is sampled only here.
  - -> RUN.
- RUN:
  - dcnt decrements each cycle.
  - When dcnt==1: outfreq toggles and dcnt reloads hp in the same cycle.
  - Each output level therefore lasts exactly hp clk cycles.
  - valid stays 1.
  - Changes on n or infreq are ignored.
- adjust=1 in any non-IDLE state: next cycle -> ARMED, valid=0, outfreq=0; the measurement in progress is discarded.
- k keeps its last measured value until the next fall in MEASURE.
- hp is never 0, because cnt is at least 1. n=0 gives out half-period = k.
- Simultaneous events:
  - adjust takes priority over rise and fall.
  - A rise and the dcnt==1 toggle cannot conflict (different states).
- rst mid-operation: immediate return to the reset values above; no partial output pulse.
- ovf is sticky until the next ARMED entry or rst. k=2^CNT_W-1 while ovf=1.

Decomposition:
- Package freq_div_pkg holds:
  - state encoding: IDLE, ARMED, WAIT_RISE, MEASURE, LOAD, RUN (3-bit);
  - default CNT_W, N_W, HP_W;
  - the constant K_MAX = 2^CNT_W-1.
- Sub-module edge_sync contains the 2-flop synchroniser and prev register, with outputs s, rise and fall.
- The FSM, measurement counter and half-period down-counter live in freq_divider.

Test Plan:
- Measure and divide by 4: infreq high/low 10 clk each, n=2, pulse adjust for 3 cycles.
  - k=10.
  - valid rises 1 cycle after fall detect.
  - outfreq high 40 clk, low 40, repeating.
- No division: same input, n=0, re-adjust.
  - outfreq half-period 10 clk; ovf=0.
- Saturation: infreq high 300 clk with CNT_W=8, n=1.
  - ovf=1, k=255.
  - outfreq half-period 510 clk.
- Re-adjust during RUN: adjust asserted in RUN.
  - valid=0 and outfreq=0 next cycle.
  - New input with 6-clk high phase and n=3 -> k=6, half-period 48 clk.
- Reset mid-measure: rst asserted in MEASURE.
  - All outputs 0 immediately; state IDLE.
  - No output activity until a new adjust.
- n change in RUN: n switched 2 -> 5 during RUN.
  - outfreq half-period stays 40 clk until the next adjust.
